// File: rtl/key_debounce.sv
// Debouncer for an active-low mechanical key: two-flop synchroniser, stable-time
// filter FSM, registered level and press/release strobes. Optional long-press
// strobe is built when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce #(
  parameter int unsigned CNT_MAX  = 1_000_000,
  parameter int unsigned LONG_MAX = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  if (CNT_MAX < 2 || LONG_MAX < 2) begin : g_param_check
    $error("key_debounce: CNT_MAX and LONG_MAX must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_FLT = 2'd1,
    PRESSED   = 2'd2,
    REL_FLT   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync;
  logic          key_s;
  logic          cnt_done_c;
  logic          press_accept_c;
  logic          rel_accept_c;

  // Two-flop synchroniser, idles released (high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], key_in};
    end
  end

  assign key_s          = sync[1];
  assign cnt_done_c     = (cnt == CW'(CNT_MAX - 1));
  assign press_accept_c = (state == PRESS_FLT) && !key_s && cnt_done_c;
  assign rel_accept_c   = (state == REL_FLT) && key_s && cnt_done_c;

  // Filter FSM; any opposite-level sample during filtering drops back to the stable state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      key_out       <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_s) begin
            state <= PRESS_FLT;
            cnt   <= '0;
          end
        end
        PRESS_FLT: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_done_c) begin
            state       <= PRESSED;
            cnt         <= '0;
            key_out     <= 1'b0;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (key_s) begin
            state <= REL_FLT;
            cnt   <= '0;
          end
        end
        REL_FLT: begin
          if (!key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt_done_c) begin
            state         <= IDLE;
            cnt           <= '0;
            key_out       <= 1'b1;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HW = (LONG_MAX > 1) ? $clog2(LONG_MAX) : 1;

  logic [HW-1:0] hold_cnt;
  logic          armed;
  logic          held_c;
  logic          hold_max_c;

  assign held_c     = (state == PRESSED) || (state == REL_FLT);
  assign hold_max_c = (hold_cnt == HW'(LONG_MAX - 1));

  // Hold timer: cleared only on a fresh accepted press, so release bounces keep it running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      armed      <= 1'b1;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_accept_c) begin
        hold_cnt <= '0;
      end else if (held_c && !hold_max_c) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      if (rel_accept_c) begin
        armed <= 1'b1;
      end else if (armed && held_c && hold_max_c) begin
        long_press <= 1'b1;
        armed      <= 1'b0;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: doc/key_debounce.md
# key_debounce

Key-input conditioning stage sitting directly upstream of the edge detector in the key path. It synchronises a raw, bouncing, active-low mechanical key input. It filters the input with a stable-time counter and produces a clean debounced level plus single-cycle press/release strobes. `key_out` idles high, matching the edge detector's idle-high reset state, and feeds its `signal` input directly.

## Interface
- `CNT_MAX`, default 1_000_000: cycles the synchronised input must be stable before a level change is accepted (20 ms @ 50 MHz); must be ≥ 2.
- `LONG_MAX`, default 50_000_000: cycles of continuous debounced press before `long_press` fires (1 s @ 50 MHz). Used only with `KEY_DEBOUNCE_LONG_PRESS_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `key_in`  in  1  raw key, active-low, asynchronous to `clk`.
- `key_out`  out  1  debounced level, active-low (0 = pressed); reset 1.
- `press_pulse`  out  1  one-cycle strobe when `key_out` falls; reset 0.
- `release_pulse`  out  1  one-cycle strobe when `key_out` rises; reset 0.
- `long_press`  out  1  one-cycle strobe per press after `LONG_MAX` held cycles; reset 0.

## Operation
- **Synchroniser**
  - Two flops, both reset to 1.
  - Output `key_s` = second flop. No logic reads `key_in` directly.
- **Filter counter**
  - Width `$clog2(CNT_MAX)`. Reset 0.
  - Cleared on every state transition.
- **FSM states** (all registered; reset state IDLE):
  - IDLE: released and stable. `key_s`=0 → PRESS_FLT, cnt=0.
  - PRESS_FLT:
    - `key_s`=1 → IDLE (bounce rejected; no output change).
    - Otherwise cnt++. When cnt==CNT_MAX-1 with `key_s`=0 → PRESSED, `key_out`←0, `press_pulse`←1.
  - PRESSED: stable pressed. `key_s`=1 → REL_FLT, cnt=0.
  - REL_FLT:
    - `key_s`=0 → PRESSED (bounce rejected).
    - Otherwise cnt++. When cnt==CNT_MAX-1 with `key_s`=1 → IDLE, `key_out`←1, `release_pulse`←1.
- **Output registers**
  - `key_out`, `press_pulse`, `release_pulse` and `long_press` are flops, not decoded from state.
  - Pulses are high for exactly one cycle.
  - `press_pulse` and `release_pulse` are never high in the same cycle.
- A single opposite-level sample during filtering restarts filtering from IDLE/PRESSED. Any bounce shorter than `CNT_MAX` cycles produces no output activity.

## Timing
- **Press latency:** `key_in` held low continuously. `key_out` falls and `press_pulse` asserts in the same cycle, CNT_MAX+3 rising edges after the first edge sampling `key_in`=0. Breakdown: 2 synchroniser + 1 IDLE→PRESS_FLT + CNT_MAX filter.
- **Release latency:** identical (CNT_MAX+3).
- **Reset mid-operation:** all state returns to reset values asynchronously: `key_out`=1, pulses=0, counters=0, synchroniser=1, IDLE. After `rst_n` deasserts with `key_in` held low, a full press latency elapses before `press_pulse`.
- **Minimum press:** accepted if low for ≥ CNT_MAX+1 consecutive sampled cycles.

## Configuration
- **`KEY_DEBOUNCE_LONG_PRESS_EN` defined**
  - Adds a hold counter of width `$clog2(LONG_MAX)`, cleared on entry to PRESSED.
  - The counter increments in PRESSED and REL_FLT and saturates.
  - `long_press` pulses for one cycle when the counter reaches LONG_MAX-1, at most once per press.
  - Re-arms only after `release_pulse`.
  - A bounce back to PRESSED during release filtering does not re-arm it and does not clear the counter.
- **Not defined**
  - Hold counter is absent.
  - `long_press` is tied to 0. The port remains so the interface is unchanged.

## Test plan
- Use CNT_MAX=8, LONG_MAX=32.
- Reset with `key_in`=1 → `key_out`=1, all pulses 0, held for 20 cycles.
- Clean press: `key_in` 1→0 at cycle 0 and held → `key_out` 0 and `press_pulse`=1 for exactly 1 cycle at cycle 11. Release likewise → `release_pulse` at release+11.
- Bounce: `key_in` toggling every 3 cycles for 40 cycles, then held 0 → no pulses during the bounce; one `press_pulse` 11 cycles after the last 1→0 edge.
- Glitch while pressed: one-cycle high pulse on `key_in` → `key_out` stays 0, no `release_pulse`.
- Reset asserted at cycle 6 of press filtering → outputs at reset values immediately. With `key_in` still 0 after deassert → `press_pulse` 11 cycles later.
- With `KEY_DEBOUNCE_LONG_PRESS_EN`: hold 100 cycles after `press_pulse` → exactly one `long_press`, 32 cycles after `press_pulse`. Without the macro → `long_press` constantly 0.
